hazard_response_ctrl: RTL and testbench

Consumer end of the hazard-detection interface. It takes the decode-stage stall and bypass decisions and turns them into registered pipeline actions: fetch/decode hold, bubble insertion into the decode→execute register, registered execute-stage operand-mux selects, and jump flush. It also keeps stall statistics and a stall watchdog. It sits between the hazard detection controller and the D/X pipeline register and execute operand muxes.

---
 rtl/hazard_response_ctrl_if.sv | 44 ++++
 rtl/hazard_response_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_response_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_response_ctrl_if.sv
// Hazard-detection -> response-controller bundle.
// master: hazard detection side (drives stall/jump/bypass/decode word).
// slave : hazard_response_ctrl (drives pipeline enables, D/X register,
//         execute selects and stall statistics).
interface hazard_response_ctrl_if;
  logic        w_stall;
  logic        w_jump_taken;
  logic        w_me_rs_bypass;
  logic        w_me_rt_bypass;
  logic        w_we_rs_bypass;
  logic        w_we_rt_bypass;
  logic        w_wm_rt_bypass;
  logic [31:0] w_dinstr_32;
  logic        w_dvalid;

  logic        w_pc_enable;
  logic        w_fd_enable;
  logic        w_fd_flush;
  logic [31:0] w_dx_instr_32;
  logic        w_dx_valid;
  logic [1:0]  w_ers_sel_2;
  logic [1:0]  w_ert_sel_2;
  logic        w_mem_wdata_sel;
  logic [15:0] w_stall_count_16;
  logic        w_stall_timeout;

  modport master (
    output w_stall, w_jump_taken, w_me_rs_bypass, w_me_rt_bypass,
           w_we_rs_bypass, w_we_rt_bypass, w_wm_rt_bypass,
           w_dinstr_32, w_dvalid,
    input  w_pc_enable, w_fd_enable, w_fd_flush, w_dx_instr_32, w_dx_valid,
           w_ers_sel_2, w_ert_sel_2, w_mem_wdata_sel, w_stall_count_16,
           w_stall_timeout
  );

  modport slave (
    input  w_stall, w_jump_taken, w_me_rs_bypass, w_me_rt_bypass,
           w_we_rs_bypass, w_we_rt_bypass, w_wm_rt_bypass,
           w_dinstr_32, w_dvalid,
    output w_pc_enable, w_fd_enable, w_fd_flush, w_dx_instr_32, w_dx_valid,
           w_ers_sel_2, w_ert_sel_2, w_mem_wdata_sel, w_stall_count_16,
           w_stall_timeout
  );
endinterface

// File: rtl/hazard_response_ctrl.sv
// hazard_response_ctrl: turns decode-stage stall/bypass decisions into
// registered pipeline actions.
// Ports:
//   clock, reset_n : pipeline clock, async active-low reset
//   hz (slave)     : stall/jump/bypass/decode inputs; PC/FD enables and
//                    FD flush (combinational); D/X instr/valid, execute
//                    operand selects, store-data select, stall count and
//                    sticky watchdog (registered).
module hazard_response_ctrl #(
  parameter int unsigned STALL_LIMIT = 64,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic             clock,
  input  logic             reset_n,
  hazard_response_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t      state, state_nxt;
  logic        eff_stall, bubble;
  logic        pc_en, fd_en, fd_flush;
  logic [31:0] dx_instr;
  logic        dx_valid;
  logic [1:0]  ers_sel, ert_sel;
  logic        mem_wdata_sel;
  logic [15:0] stall_cnt, run_cnt;
  logic        timeout;

  // A jump squashes whatever is in decode, so its stall request is moot.
  assign eff_stall = hz.w_stall & hz.w_dvalid & ~hz.w_jump_taken;
  assign bubble    = eff_stall | hz.w_jump_taken;

  // mem->exec is the younger producer, so it wins over wb->exec.
  function automatic logic [1:0] sel_enc(input logic me, input logic we);
    return me ? 2'd1 : (we ? 2'd2 : 2'd0);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  // Enables follow the live stall request so an N-cycle stall costs exactly
  // N bubbles; the cycle after STALL forwards the held instruction as RUN.
  always_comb begin
    state_nxt = state;
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    fd_flush  = 1'b0;
    case (state)
      STALL:   state_nxt = eff_stall ? STALL : RUN;
      default: state_nxt = eff_stall ? STALL : RUN;  // RUN, FLUSH
    endcase
    if (eff_stall) begin
      pc_en = 1'b0;
      fd_en = 1'b0;
    end
    if (hz.w_jump_taken) begin
      state_nxt = FLUSH;
      fd_flush  = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dx_instr      <= NOP_WORD;
      dx_valid      <= 1'b0;
      ers_sel       <= 2'd0;
      ert_sel       <= 2'd0;
      mem_wdata_sel <= 1'b0;
      stall_cnt     <= 16'd0;
      run_cnt       <= 16'd0;
      timeout       <= 1'b0;
    end else begin
      if (bubble) begin
        dx_instr <= NOP_WORD;
        dx_valid <= 1'b0;
        ers_sel  <= 2'd0;
        ert_sel  <= 2'd0;
      end else begin
        dx_instr <= hz.w_dinstr_32;
        dx_valid <= hz.w_dvalid;
        ers_sel  <= sel_enc(hz.w_me_rs_bypass, hz.w_we_rs_bypass);
        ert_sel  <= sel_enc(hz.w_me_rt_bypass, hz.w_we_rt_bypass);
      end
      mem_wdata_sel <= hz.w_wm_rt_bypass;
      // Only cycles that actually hold the front end count as stall cycles.
      if (eff_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (eff_stall) begin
        if (run_cnt != 16'hFFFF) run_cnt <= run_cnt + 16'd1;
        if (run_cnt == 16'(STALL_LIMIT - 1)) timeout <= 1'b1;
      end else begin
        run_cnt <= 16'd0;
      end
    end
  end

  assign hz.w_pc_enable      = pc_en;
  assign hz.w_fd_enable      = fd_en;
  assign hz.w_fd_flush       = fd_flush;
  assign hz.w_dx_instr_32    = dx_instr;
  assign hz.w_dx_valid       = dx_valid;
  assign hz.w_ers_sel_2      = ers_sel;
  assign hz.w_ert_sel_2      = ert_sel;
  assign hz.w_mem_wdata_sel  = mem_wdata_sel;
  assign hz.w_stall_count_16 = stall_cnt;
  assign hz.w_stall_timeout  = timeout;

endmodule

// File: tb/tb_hazard_response_ctrl.sv
module tb_hazard_response_ctrl;
  localparam int LIM = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  hazard_response_ctrl_if hz();
  hazard_response_ctrl_if hs();

  hazard_response_ctrl #(.STALL_LIMIT(LIM), .NOP_WORD(32'h0)) dut (
    .clock(clock), .reset_n(reset_n), .hz(hz.slave));
  hazard_response_ctrl #(.STALL_LIMIT(65535), .NOP_WORD(32'h0)) dut_sat (
    .clock(clock), .reset_n(reset_n), .hz(hs.slave));

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic [1:0]  rs, rt;
    logic        wsel;
    logic [15:0] cnt;
    logic        tmo;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int m_cnt, m_run;
  bit m_tmo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] sel_of(input bit me, input bit we);
    if (me) return 2'd1;
    if (we) return 2'd2;
    return 2'd0;
  endfunction

  // Monitor: each edge after stimulus pops the expected D/X contents.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("dx_instr", hz.w_dx_instr_32, e.instr);
      chk("dx_valid", 32'(hz.w_dx_valid), 32'(e.valid));
      chk("ers_sel", 32'(hz.w_ers_sel_2), 32'(e.rs));
      chk("ert_sel", 32'(hz.w_ert_sel_2), 32'(e.rt));
      chk("mem_wdata_sel", 32'(hz.w_mem_wdata_sel), 32'(e.wsel));
      chk("stall_count", 32'(hz.w_stall_count_16), 32'(e.cnt));
      chk("timeout", 32'(hz.w_stall_timeout), 32'(e.tmo));
    end
  end

  task automatic step(input bit st, input bit jt, input bit dv, input logic [31:0] ins,
                      input bit mrs, input bit mrt, input bit wrs, input bit wrt, input bit wmt);
    exp_t e;
    bit   stall_now, squash;
    @(negedge clock);
    hz.w_stall = st; hz.w_jump_taken = jt; hz.w_dvalid = dv; hz.w_dinstr_32 = ins;
    hz.w_me_rs_bypass = mrs; hz.w_me_rt_bypass = mrt;
    hz.w_we_rs_bypass = wrs; hz.w_we_rt_bypass = wrt; hz.w_wm_rt_bypass = wmt;
    #1;
    stall_now = st && dv && !jt;
    squash    = stall_now || jt;
    chk("pc_enable", 32'(hz.w_pc_enable), 32'(!stall_now));
    chk("fd_enable", 32'(hz.w_fd_enable), 32'(!stall_now));
    chk("fd_flush", 32'(hz.w_fd_flush), 32'(jt));
    e.instr = squash ? 32'h0 : ins;
    e.valid = squash ? 1'b0 : dv;
    e.rs    = squash ? 2'd0 : sel_of(mrs, wrs);
    e.rt    = squash ? 2'd0 : sel_of(mrt, wrt);
    e.wsel  = wmt;
    if (stall_now) begin
      if (m_cnt < 65535) m_cnt++;
      m_run++;
      if (m_run >= LIM) m_tmo = 1'b1;
    end else begin
      m_run = 0;
    end
    e.cnt = 16'(m_cnt);
    e.tmo = m_tmo;
    q.push_back(e);
  endtask

  task automatic idle_hz();
    hz.w_stall = 0; hz.w_jump_taken = 0; hz.w_dvalid = 0; hz.w_dinstr_32 = 0;
    hz.w_me_rs_bypass = 0; hz.w_me_rt_bypass = 0; hz.w_we_rs_bypass = 0;
    hz.w_we_rt_bypass = 0; hz.w_wm_rt_bypass = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    {hz.w_stall, hz.w_jump_taken, hz.w_dvalid, hz.w_me_rs_bypass, hz.w_me_rt_bypass,
     hz.w_we_rs_bypass, hz.w_we_rt_bypass, hz.w_wm_rt_bypass} = 8'($urandom);
    hz.w_dinstr_32 = $urandom;
    reset_n = 1'b0;
    q.delete();
    m_cnt = 0; m_run = 0; m_tmo = 1'b0;
    #1;
    chk("rst_dx_instr", hz.w_dx_instr_32, 32'h0);
    chk("rst_dx_valid", 32'(hz.w_dx_valid), 32'h0);
    chk("rst_sels", 32'({hz.w_ers_sel_2, hz.w_ert_sel_2, hz.w_mem_wdata_sel}), 32'h0);
    chk("rst_count", 32'(hz.w_stall_count_16), 32'h0);
    chk("rst_timeout", 32'(hz.w_stall_timeout), 32'h0);
    repeat (2) @(negedge clock);
    idle_hz();
    reset_n = 1'b1;
    #1;
    chk("rst_pc_enable", 32'(hz.w_pc_enable), 32'h1);
    chk("rst_fd_enable", 32'(hz.w_fd_enable), 32'h1);
    chk("rst_fd_flush", 32'(hz.w_fd_flush), 32'h0);
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  initial begin
    idle_hz();
    hs.w_stall = 0; hs.w_jump_taken = 0; hs.w_dvalid = 0; hs.w_dinstr_32 = 0;
    hs.w_me_rs_bypass = 0; hs.w_me_rt_bypass = 0; hs.w_we_rs_bypass = 0;
    hs.w_we_rt_bypass = 0; hs.w_wm_rt_bypass = 0;
    do_reset();

    // Load-use: one stall cycle, then the held instruction goes through.
    step(1, 0, 1, 32'h8C22_0004, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h8C22_0004, 0, 0, 0, 0, 0);
    settle();
    chk("loaduse_count", 32'(hz.w_stall_count_16), 32'd1);

    // Forwarding priority and store-data select.
    step(0, 0, 1, 32'h0000_1111, 1, 0, 1, 0, 0);
    step(0, 0, 1, 32'h0000_2222, 0, 0, 0, 1, 1);
    step(0, 0, 1, 32'h0000_3333, 1, 1, 1, 1, 0);

    // Jump on top of a stall: flush only, no count.
    step(1, 0, 1, 32'hAAAA_0001, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'hAAAA_0001, 1, 1, 0, 0, 0);
    step(0, 0, 1, 32'hBBBB_0002, 0, 1, 0, 0, 0);

    // Reset in the middle of a stall clears at once.
    step(1, 0, 1, 32'hCCCC_0003, 0, 0, 0, 0, 0);
    step(1, 0, 1, 32'hCCCC_0003, 0, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 1, 32'hDDDD_0004, 0, 0, 1, 0, 0);

    // Watchdog: 3 on / 1 off / 3 on never reaches the limit.
    for (int k = 0; k < 2; k++) begin
      repeat (3) step(1, 0, 1, 32'h1234_5678, 0, 0, 0, 0, 0);
      step(0, 0, 1, 32'h1234_5678, 0, 0, 0, 0, 0);
    end
    settle();
    chk("wd_gap_timeout", 32'(hz.w_stall_timeout), 32'h0);
    repeat (4) step(1, 0, 1, 32'h9999_0000, 0, 0, 0, 0, 0);
    settle();
    chk("wd_hit_timeout", 32'(hz.w_stall_timeout), 32'h1);
    step(0, 0, 1, 32'h9999_0000, 0, 0, 0, 0, 0);
    settle();
    chk("wd_sticky", 32'(hz.w_stall_timeout), 32'h1);

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      step($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 8,
           $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    settle();
    chk("queue_drained", 32'(q.size()), 32'd0);

    // Counter saturation on the long-limit instance.
    do_reset();
    @(negedge clock);
    hs.w_stall = 1; hs.w_dvalid = 1; hs.w_dinstr_32 = 32'h5555_AAAA;
    repeat (65534) @(posedge clock);
    #1;
    chk("sat_count_pre", 32'(hs.w_stall_count_16), 32'hFFFE);
    chk("sat_timeout_pre", 32'(hs.w_stall_timeout), 32'h0);
    @(posedge clock);
    #1;
    chk("sat_count_full", 32'(hs.w_stall_count_16), 32'hFFFF);
    chk("sat_timeout", 32'(hs.w_stall_timeout), 32'h1);
    repeat (5) @(posedge clock);
    #1;
    chk("sat_no_wrap", 32'(hs.w_stall_count_16), 32'hFFFF);
    chk("sat_hold_pc", 32'(hs.w_pc_enable), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
